db_fill_drain_ctrl: RTL and testbench

DB_FILL_DRAIN_CTRL -- requirements
Module: db_fill_drain_ctrl

---
 rtl/db_fill_drain_ctrl_pkg.sv | 19 +
 rtl/db_addr_counter.sv | 46 ++++
 rtl/db_fill_drain_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_db_fill_drain_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/db_fill_drain_ctrl_pkg.sv
// Shared state encoding and length decode helpers for the double-buffer fill/drain controller.
package db_fill_drain_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_LAST  = 2'd3
    } state_t;

    // A programmed repeat count of zero still drains the bank once.
    localparam int unsigned MIN_REPS = 1;

    // A programmed value of zero selects the full range.
    function automatic int unsigned decode_len(input int unsigned len, input int unsigned full);
        return (len == 32'd0) ? full : len;
    endfunction

endpackage

// File: rtl/db_addr_counter.sv
// Address sweep counter: walks 0..limit-1 for the requested number of passes, then holds done.
module db_addr_counter #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned PASS_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   limit,
    input  logic [PASS_WIDTH-1:0] passes,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_c,
    output logic                  done
);
    localparam int unsigned LW = ADDR_WIDTH + 1;

    logic [PASS_WIDTH-1:0] pass;
    logic                  wrap_c;

    assign wrap_c = ({1'b0, addr} == (limit - LW'(1)));
    assign last_c = inc && wrap_c && (pass == (passes - PASS_WIDTH'(1)));

    // The final pass holds its last address until the bank swap clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            pass <= '0;
            done <= 1'b0;
        end else if (clr) begin
            addr <= '0;
            pass <= '0;
            done <= 1'b0;
        end else if (inc && !done) begin
            if (last_c) begin
                done <= 1'b1;
            end else if (wrap_c) begin
                addr <= '0;
                pass <= pass + PASS_WIDTH'(1);
            end else begin
                addr <= addr + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/db_fill_drain_ctrl.sv
// Ping-pong buffer controller: fills one bank from a stream while draining the other.
// Optional stall_cycles performance counter is built when DB_CTRL_PERF_CNT_EN is defined.
module db_fill_drain_ctrl
    import db_fill_drain_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned BANK_ADDR_WIDTH = 7,
    parameter int unsigned REP_WIDTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       fin,
    input  logic [BANK_ADDR_WIDTH:0]   fill_len,
    input  logic [BANK_ADDR_WIDTH:0]   drain_len,
    input  logic [REP_WIDTH-1:0]       drain_reps,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] wadr,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] radr,
    output logic                       switch_banks,
    output logic                       busy,
    output logic                       done
`ifdef DB_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);
    localparam int unsigned LW         = BANK_ADDR_WIDTH + 1;
    localparam int unsigned BANK_DEPTH = 2 ** BANK_ADDR_WIDTH;

    state_t               state;
    state_t               state_nxt;
    logic [LW-1:0]        fill_lim;
    logic [LW-1:0]        drain_lim;
    logic [REP_WIDTH-1:0] reps_lim;
    logic                 fin_seen;
    logic                 fill_last_c;
    logic                 fill_done;
    logic                 drain_last_c;
    logic                 drain_done;
    logic                 fill_act_c;
    logic                 drain_act_c;
    logic                 fill_end_c;
    logic                 drain_end_c;
    logic                 fin_any_c;
    logic                 load_c;
    logic                 swap_c;
    logic                 ctr_clr_c;

    // Both sides are frozen during the swap cycle so no access straddles it.
    assign fill_act_c  = ((state == ST_PRIME) || (state == ST_RUN)) && !fill_done && !switch_banks;
    assign drain_act_c = ((state == ST_RUN) || (state == ST_LAST)) && !drain_done && !switch_banks;
    assign in_ready    = fill_act_c;
    assign wen         = in_valid && fill_act_c;
    assign wdata       = in_data;
    assign ren         = out_ready && drain_act_c;
    assign busy        = (state != ST_IDLE);
    assign fill_end_c  = fill_done || fill_last_c;
    assign drain_end_c = drain_done || drain_last_c;
    assign fin_any_c   = fin_seen || fin;
    assign ctr_clr_c   = swap_c || (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Swap once every side the current state needs has finished.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        swap_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (fill_end_c && !switch_banks) begin
                    swap_c    = 1'b1;
                    state_nxt = fin_any_c ? ST_LAST : ST_RUN;
                end
            end
            ST_RUN: begin
                if (fill_end_c && drain_end_c && !switch_banks) begin
                    swap_c    = 1'b1;
                    state_nxt = fin_any_c ? ST_LAST : ST_RUN;
                end
            end
            ST_LAST: begin
                if (drain_end_c && !switch_banks) begin
                    swap_c    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_lim     <= '0;
            drain_lim    <= '0;
            reps_lim     <= '0;
            fin_seen     <= 1'b0;
            switch_banks <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            switch_banks <= swap_c;
            done         <= swap_c && (state == ST_LAST);
            out_valid    <= ren;
            if (load_c) begin
                fill_lim  <= LW'(decode_len(32'(fill_len), BANK_DEPTH));
                drain_lim <= LW'(decode_len(32'(drain_len), BANK_DEPTH));
                reps_lim  <= REP_WIDTH'(decode_len(32'(drain_reps), MIN_REPS));
                fin_seen  <= fin;
            end else if (swap_c) begin
                fin_seen <= 1'b0;
            end else if (fin && ((state == ST_PRIME) || (state == ST_RUN))) begin
                fin_seen <= 1'b1;
            end
        end
    end

    db_addr_counter #(
        .ADDR_WIDTH (BANK_ADDR_WIDTH),
        .PASS_WIDTH (1)
    ) u_fill_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ctr_clr_c),
        .inc    (wen),
        .limit  (fill_lim),
        .passes (1'b1),
        .addr   (wadr),
        .last_c (fill_last_c),
        .done   (fill_done)
    );

    db_addr_counter #(
        .ADDR_WIDTH (BANK_ADDR_WIDTH),
        .PASS_WIDTH (REP_WIDTH)
    ) u_drain_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ctr_clr_c),
        .inc    (ren),
        .limit  (drain_lim),
        .passes (reps_lim),
        .addr   (radr),
        .last_c (drain_last_c),
        .done   (drain_done)
    );

`ifdef DB_CTRL_PERF_CNT_EN
    // Cycles where the consumer holds up the next swap; saturates rather than wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (load_c) begin
            stall_cycles <= '0;
        end else if ((state == ST_RUN) && fill_done && !drain_done && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_db_fill_drain_ctrl.sv
// Randomized bench for db_fill_drain_ctrl against a per-bank transaction-count model.
module tb_db_fill_drain_ctrl;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 7;
    localparam int unsigned RW    = 4;
    localparam int unsigned LW    = AW + 1;
    localparam int          DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          fin;
    logic [LW-1:0] fill_len;
    logic [LW-1:0] drain_len;
    logic [RW-1:0] drain_reps;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic          wen;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] radr;
    logic          switch_banks;
    logic          busy;
    logic          done;
`ifdef DB_CTRL_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    db_fill_drain_ctrl #(
        .DATA_WIDTH      (DW),
        .BANK_ADDR_WIDTH (AW),
        .REP_WIDTH       (RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fin          (fin),
        .fill_len     (fill_len),
        .drain_len    (drain_len),
        .drain_reps   (drain_reps),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .wen          (wen),
        .wadr         (wadr),
        .wdata        (wdata),
        .ren          (ren),
        .radr         (radr),
        .switch_banks (switch_banks),
        .busy         (busy),
        .done         (done)
`ifdef DB_CTRL_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: segment k of a job fills block k (k < nblk) and drains block k-1 (k >= 1).
    int m_fl = 1, m_dl = 1, m_rp = 1, m_nblk = 1;
    int m_seg = 0, m_wcnt = 0, m_rcnt = 0, m_stall = 0;
    bit m_active = 0, m_sw = 0, m_done = 0, m_prev_ren = 0;
    int fin_mode = 0, p_valid = 100, p_ready = 100, hold_left = 0;
    bit fin_sent = 0, start_req = 0, noise = 0;
    int sw_obs = 0, done_obs = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit sw_now, fill_need, drain_need, exp_wen, exp_ren, stall_now;
        int tgt;
        tgt        = m_dl * m_rp;
        sw_now     = m_sw;
        fill_need  = m_active && (m_seg < m_nblk) && (m_wcnt < m_fl) && !sw_now;
        drain_need = m_active && (m_seg >= 1) && (m_rcnt < tgt) && !sw_now;
        start      = 1'b0;
        fin        = 1'b0;
        in_valid   = ($urandom_range(99) < 32'(p_valid));
        in_data    = {$urandom, $urandom};
        out_ready  = ($urandom_range(99) < 32'(p_ready));
        if (start_req) begin
            start     = 1'b1;
            fin       = (fin_mode == 2);
            fin_sent  = (fin_mode == 2);
            start_req = 0;
        end else if (noise && m_active && ($urandom_range(15) == 0)) begin
            start      = 1'b1;
            fill_len   = LW'($urandom);
            drain_len  = LW'($urandom);
            drain_reps = RW'($urandom);
        end
        if (!fin_sent && fill_need && (m_seg == m_nblk - 1)) begin
            if (fin_mode == 0 && m_wcnt == 0) begin
                fin = 1'b1; fin_sent = 1;
            end
            if (fin_mode == 1 && m_wcnt == m_fl - 1) begin
                fin = 1'b1; in_valid = 1'b1; fin_sent = 1;
            end
        end
        if (hold_left > 0 && drain_need && m_seg == 1 && m_wcnt == m_fl) begin
            out_ready = 1'b0;
            hold_left--;
        end
        #1;
        exp_wen = fill_need && in_valid;
        exp_ren = drain_need && out_ready;
        check("switch_banks", 64'(switch_banks), 64'(sw_now));
        check("done", 64'(done), 64'(m_done));
        check("busy", 64'(busy), 64'(m_active));
        check("out_valid", 64'(out_valid), 64'(m_prev_ren));
        check("in_ready", 64'(in_ready), 64'(fill_need));
        check("wen", 64'(wen), 64'(exp_wen));
        check("ren", 64'(ren), 64'(exp_ren));
        if (exp_wen && wen) begin
            check("wadr", 64'(wadr), 64'(m_wcnt));
            check("wdata", wdata, in_data);
        end
        if (exp_ren && ren) check("radr", 64'(radr), 64'(m_rcnt % m_dl));
`ifdef DB_CTRL_PERF_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
        sw_obs   += int'(switch_banks);
        done_obs += int'(done);
        stall_now = m_active && (m_seg >= 1) && (m_seg < m_nblk) && (m_wcnt == m_fl)
                    && (m_rcnt < tgt) && !sw_now;
        if (stall_now) m_stall++;
        if (exp_wen) m_wcnt++;
        if (exp_ren) m_rcnt++;
        m_prev_ren = exp_ren;
        m_done     = 0;
        if (start && !m_active) begin
            m_fl     = (fill_len == 0) ? DEPTH : int'(fill_len);
            m_dl     = (drain_len == 0) ? DEPTH : int'(drain_len);
            m_rp     = (drain_reps == 0) ? 1 : int'(drain_reps);
            m_active = 1; m_seg = 0; m_wcnt = 0; m_rcnt = 0; m_stall = 0;
        end
        m_sw = m_active && !sw_now && ((m_seg >= m_nblk) || (m_wcnt == m_fl))
               && ((m_seg == 0) || (m_rcnt == m_dl * m_rp));
        if (m_sw) begin
            m_seg++; m_wcnt = 0; m_rcnt = 0;
            if (m_seg > m_nblk) begin
                m_active = 0; m_done = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_job(input int fl, input int dl, input int rp, input int nblk,
                           input int fmode, input int pv, input int pr, input int hold);
        bit timed_out;
        fill_len   = LW'(fl);
        drain_len  = LW'(dl);
        drain_reps = RW'(rp);
        m_nblk = nblk; fin_mode = fmode; fin_sent = 0;
        p_valid = pv; p_ready = pr; hold_left = hold;
        sw_obs = 0; done_obs = 0; start_req = 1;
        step();
        timed_out = 1;
        for (int i = 0; i < 20000; i++) begin
            if (!(m_active || m_sw || m_done)) begin
                timed_out = 0;
                break;
            end
            step();
        end
        check("job_complete", 64'(timed_out), 64'(0));
        check("job_busy_end", 64'(busy), 64'(0));
        check("switch_count", 64'(sw_obs), 64'(nblk + 1));
        check("done_count", 64'(done_obs), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; fin = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; fill_len = '0; drain_len = '0; drain_reps = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'(0));
        check("rst wen", 64'(wen), 64'(0));
        check("rst ren", 64'(ren), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst switch_banks", 64'(switch_banks), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst out_valid", 64'(out_valid), 64'(0));
`ifdef DB_CTRL_PERF_CNT_EN
        check("rst stall_cycles", 64'(stall_cycles), 64'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_job(4, 4, 1, 3, 0, 100, 100, 0);   // three blocks, fin with the third
        run_job(6, 3, 2, 2, 1, 100, 100, 0);   // two drain passes; fin with last write
        run_job(0, 2, 1, 2, 0, 100, 100, 0);   // full-depth fill
        run_job(4, 4, 3, 3, 0, 100, 100, 10);  // consumer stalls after fill completes
        run_job(5, 5, 0, 1, 2, 70, 70, 0);     // fin together with start, reps 0
        run_job(3, 7, 1, 1, 0, 60, 80, 0);     // fin in PRIME goes straight to LAST

        noise = 1;
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(20, 1), $urandom_range(12, 1), $urandom_range(3, 0),
                    $urandom_range(4, 1), $urandom_range(1, 0),
                    $urandom_range(100, 30), $urandom_range(100, 30), 0);
        end
        noise = 0;

        // Reset in the middle of RUN with a partly written bank.
        fill_len = LW'(8); drain_len = LW'(4); drain_reps = RW'(1);
        m_nblk = 3; fin_mode = 0; fin_sent = 0; p_valid = 100; p_ready = 100;
        hold_left = 0; start_req = 1;
        step();
        for (int i = 0; i < 200 && !(m_seg == 1 && m_wcnt == 2 && !m_sw); i++) step();
        #1;
        check("pre-reset wen", 64'(wen), 64'(1));
        check("pre-reset wadr", 64'(wadr), 64'(2));
        rst_n = 1'b0;
        #1;
        check("mid-rst in_ready", 64'(in_ready), 64'(0));
        check("mid-rst wen", 64'(wen), 64'(0));
        check("mid-rst ren", 64'(ren), 64'(0));
        check("mid-rst busy", 64'(busy), 64'(0));
        check("mid-rst switch_banks", 64'(switch_banks), 64'(0));
        check("mid-rst done", 64'(done), 64'(0));
        check("mid-rst out_valid", 64'(out_valid), 64'(0));
        m_active = 0; m_sw = 0; m_done = 0; m_prev_ren = 0; m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(8, 4, 1, 2, 0, 100, 100, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
